// File: rtl/debounce_multi_if.sv
// Button bundle between the pins/consumers and debounce_multi.
// btn_in: raw pins; btn_level/press/release/long_press: conditioned outputs.
interface debounce_multi_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic [N_CH-1:0] long_press;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  long_press
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output long_press
  );
endinterface

// File: rtl/debounce_multi.sv
// N-channel button conditioner: 2-FF sync, symmetric debounce, event pulses.
// Ports: clk_1k (1 kHz), rst (sync, active-high), bus (slave: pins in, events out).
module debounce_multi #(
  parameter int N_CH       = 4,
  parameter int STABLE_MS  = 16,
  parameter int LONG_MS    = 1000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk_1k,
  input  logic              rst,
  debounce_multi_if.slave   bus
);
  localparam int CNT_W = $clog2(STABLE_MS);
  localparam logic REL = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STABLE_MS - 1);

  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;
  logic [N_CH-1:0] s;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] done;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] rel;
  logic [CNT_W-1:0] cnt [N_CH];

  // s is the synchronised sample in "1 = pressed" polarity
  assign s = s2 ^ {N_CH{REL}};

  // done: this edge accepts the STABLE_MS-th consecutive differing sample
  always_comb begin
    done = '0;
    for (int i = 0; i < N_CH; i++) begin
      done[i] = (s[i] != level[i]) && (cnt[i] == CNT_TOP);
    end
  end

  always_ff @(posedge clk_1k) begin
    if (rst) begin
      s1    <= {N_CH{REL}};
      s2    <= {N_CH{REL}};
      level <= '0;
      press <= '0;
      rel   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1    <= bus.btn_in;
      s2    <= s1;
      level <= level ^ done;
      press <= done & s;
      rel   <= done & ~s;
      for (int i = 0; i < N_CH; i++) begin
        if (s[i] == level[i] || done[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = rel;

  if (LONG_MS > 0) begin : g_long
    localparam int HOLD_W = $clog2(LONG_MS + 1);
    localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(LONG_MS);

    logic [HOLD_W-1:0] hold [N_CH];
    logic [N_CH-1:0]   lp;

    // hold counts edges since the press while held; a release edge
    // clears it so the long pulse can never coincide with release
    always_ff @(posedge clk_1k) begin
      if (rst) begin
        lp <= '0;
        for (int i = 0; i < N_CH; i++) begin
          hold[i] <= '0;
        end
      end else begin
        for (int i = 0; i < N_CH; i++) begin
          lp[i] <= level[i] && !done[i] &&
                   (hold[i] == HOLD_TOP - 1'b1);
          if (!level[i] || done[i]) begin
            hold[i] <= '0;
          end else if (hold[i] != HOLD_TOP) begin
            hold[i] <= hold[i] + 1'b1;
          end
        end
      end
    end

    assign bus.long_press = lp;
  end else begin : g_no_long
    assign bus.long_press = '0;
  end
endmodule
